npu_wb_stream_bridge: RTL and testbench
=======================================

Name: npu_wb_stream_bridge

Overview:
Wishbone-slave front-end that sits directly upstream of the npu core. It converts single-beat Wishbone writes into a buffered command stream toward the core, and Wishbone reads into pops from a buffered response stream coming back from the core. There is no address bus: every write is a command push and every read is a response pop. Bounded stall timeouts keep the management SoC from hanging on a full or empty buffer.

Parameters:
- DEPTH, 4: entries per FIFO (command and response); power of two, ≥2.
- TIMEOUT, 64: wait cycles before a stalled access is force-acked; ≥1.
- DW, 32: data width of Wishbone and streams.

Ports:
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_i  in  1  synchronous reset, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  1 = write (command push), 0 = read (response pop).
- wbs_dat_i  in  DW  write data.
- wbs_ack_o  out  1  registered single-cycle acknowledge.
- wbs_dat_o  out  DW  read data.
- cmd_valid_o  out  1  command FIFO non-empty.
- cmd_data_o  out  DW  command FIFO head (first-word-fall-through).
- cmd_ready_i  in  1  core accepts command.
- rsp_valid_i  in  1  core presents response.
- rsp_data_i  in  DW  response word.
- rsp_ready_o  out  1  response FIFO not full.
- ovf_cnt_o  out  8  saturating count of writes dropped on timeout.
- udf_cnt_o  out  8  saturating count of reads timed out on empty.

Behaviour:
- Request: req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o. ack is high for exactly one cycle per access; it is never high on two consecutive cycles.
- States: IDLE, WAIT.
- IDLE, write request, cmd FIFO not full: push wbs_dat_i at this edge; ack next cycle; wbs_dat_o = 0 on that ack.
- IDLE, read request, rsp FIFO not empty: wbs_dat_o <= head; pop; ack next cycle.
- Latency: request sampled at cycle N, ack high at cycle N+1.
- Otherwise (write into full, or read from empty): go to WAIT with wait_cnt = 1.
- WAIT: re-evaluate every cycle.
  - If the condition clears, complete as in IDLE (push or pop, ack next cycle) and return to IDLE.
  - If wait_cnt == TIMEOUT, force ack next cycle and return to IDLE. A forced write drops its data (ovf_cnt_o++). A forced read returns 32'hFFFF_FFFF (udf_cnt_o++).
  - Else wait_cnt++.
  - If cyc or stb drops while in WAIT: abandon the access with no push, pop or ack, and return to IDLE.
- "Full" and "empty" are evaluated on registered occupancy at the start of the cycle. A same-cycle pop by the core does not let a write into a full FIFO that cycle.
- Command side: cmd_valid_o = ~cmd_empty; a pop happens when cmd_valid_o & cmd_ready_i. A push and a pop in the same cycle are both legal; occupancy is unchanged.
- Response side: rsp_ready_o = ~rsp_full; a push happens when rsp_valid_i & rsp_ready_o. A simultaneous push and Wishbone pop are legal.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. full = MSBs differ and LSBs equal; empty = pointers equal.
- Counters saturate at 255 and never wrap.
- wbs_dat_o holds its value between acks.
- Reset, including mid-access: both FIFOs flush; state = IDLE, wait_cnt = 0.
  - Output reset values: wbs_ack_o = 0, wbs_dat_o = 0, cmd_valid_o = 0, cmd_data_o = 0, rsp_ready_o = 1, ovf_cnt_o = 0, udf_cnt_o = 0.
  - An access still asserted after reset releases is treated as a new request.

Decomposition:
- Shared package npu_pkg: DW, DEPTH, TIMEOUT defaults; RD_EMPTY_PATTERN = 32'hFFFF_FFFF; state enum {IDLE, WAIT}.
- One sub-module, npu_sync_fifo (params DW, DEPTH): push, pop, data in/out, full, empty, same synchronous reset. Instantiated twice (command, response).
- Bridge FSM, timeout counter and saturating counters stay in the top.

Test Plan:
- Write 32'h0000_0011 with cmd_ready_i = 0 -> ack at N+1, cmd_valid_o = 1, cmd_data_o = 0x11. Raise cmd_ready_i for one cycle -> cmd_valid_o = 0.
- Four writes 0xA0..0xA3 with cmd_ready_i = 0, then a fifth write 0xA4:
  - No ack for 64 cycles, forced ack at cycle 65, ovf_cnt_o = 1.
  - Draining yields A0..A3 only.
- Read with rsp FIFO empty, then rsp_valid_i pulses 0xBEEF at wait cycle 10 -> ack one cycle after the push; wbs_dat_o = 0xBEEF; udf_cnt_o = 0.
- Read with rsp FIFO empty and no response -> ack after TIMEOUT, wbs_dat_o = 0xFFFF_FFFF, udf_cnt_o = 1.
- Core pushes responses 1..4 with rsp_valid_i held:
  - rsp_ready_o drops after the 4th; a 5th response 5 is held by the core.
  - One Wishbone read returns 1; rsp_ready_o rises and 5 is accepted.
  - Following reads return 2, 3, 4, 5.
- Assert wb_rst_i during WAIT of a full-FIFO write -> next cycle ack = 0, cmd_valid_o = 0, rsp_ready_o = 1, counters = 0.
  - With the access still asserted after release, the write completes with ack at N+1.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared constants and helpers for the npu Wishbone stream bridge.
package npu_pkg;

  localparam int NPU_DW      = 32;
  localparam int NPU_DEPTH   = 4;
  localparam int NPU_TIMEOUT = 64;

  localparam logic [31:0] RD_EMPTY_PATTERN = 32'hFFFF_FFFF;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers.
module npu_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head reads as zero when empty so a flushed FIFO presents no stale data.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/npu_wb_stream_bridge.sv
// Wishbone slave turning writes into command pushes and reads into response pops.
// state   | meaning
// ST_IDLE | no access pending; a new request completes at once or stalls
// ST_WAIT | stalled on full cmd / empty rsp FIFO, counting toward the force-ack
module npu_wb_stream_bridge
  import npu_pkg::*;
#(
  parameter int DEPTH   = NPU_DEPTH,
  parameter int TIMEOUT = NPU_TIMEOUT,
  parameter int DW      = NPU_DW
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [DW-1:0] wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [DW-1:0] wbs_dat_o,
  output logic          cmd_valid_o,
  output logic [DW-1:0] cmd_data_o,
  input  logic          cmd_ready_i,
  input  logic          rsp_valid_i,
  input  logic [DW-1:0] rsp_data_i,
  output logic          rsp_ready_o,
  output logic [7:0]    ovf_cnt_o,
  output logic [7:0]    udf_cnt_o
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT);
  localparam logic [DW-1:0]  RD_EMPTY   = DW'(RD_EMPTY_PATTERN);

  logic [0:0]     state;
  logic [WCW-1:0] wait_cnt;
  logic           req;
  logic           cmd_full;
  logic           cmd_empty;
  logic           rsp_full;
  logic           rsp_empty;
  logic [DW-1:0]  rsp_head;
  logic           cmd_push;
  logic           rsp_pop;
  logic           done;

  assign req         = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign cmd_valid_o = ~cmd_empty;
  assign rsp_ready_o = ~rsp_full;

  // Full/empty come from registered occupancy, so a same-cycle core pop never frees a slot.
  assign cmd_push = req &  wbs_we_i & ~cmd_full;
  assign rsp_pop  = req & ~wbs_we_i & ~rsp_empty;
  assign done     = cmd_push | rsp_pop;

  npu_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (cmd_push),
    .din   (wbs_dat_i),
    .pop   (cmd_ready_i),
    .dout  (cmd_data_o),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  npu_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (rsp_valid_i),
    .din   (rsp_data_i),
    .pop   (rsp_pop),
    .dout  (rsp_head),
    .full  (rsp_full),
    .empty (rsp_empty)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      ovf_cnt_o <= '0;
      udf_cnt_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (done) begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= wbs_we_i ? '0 : rsp_head;
          end else if (req) begin
            state    <= ST_WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        default: begin
          if (!req) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else if (done) begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= wbs_we_i ? '0 : rsp_head;
            state     <= ST_IDLE;
            wait_cnt  <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            wbs_ack_o <= 1'b1;
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            if (wbs_we_i) begin
              wbs_dat_o <= '0;
              ovf_cnt_o <= sat_inc8(ovf_cnt_o);
            end else begin
              wbs_dat_o <= RD_EMPTY;
              udf_cnt_o <= sat_inc8(udf_cnt_o);
            end
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npu_wb_stream_bridge.sv
// Self-checking bench for npu_wb_stream_bridge: directed table, corner sequences, random vs queue model.
module tb_npu_wb_stream_bridge;

  localparam int DW      = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int LAT_OK  = 1;
  localparam int LAT_TO  = TIMEOUT + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stb = 1'b0;
  logic          cyc = 1'b0;
  logic          we  = 1'b0;
  logic [DW-1:0] wdat = '0;
  logic          ack;
  logic [DW-1:0] rdat;
  logic          cmd_valid;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready = 1'b0;
  logic          rsp_valid = 1'b0;
  logic [DW-1:0] rsp_data = '0;
  logic          rsp_ready;
  logic [7:0]    ovf_cnt;
  logic [7:0]    udf_cnt;

  int checks = 0;
  int errors = 0;

  npu_wb_stream_bridge #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .DW(DW)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_stb_i   (stb),
    .wbs_cyc_i   (cyc),
    .wbs_we_i    (we),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .cmd_valid_o (cmd_valid),
    .cmd_data_o  (cmd_data),
    .cmd_ready_i (cmd_ready),
    .rsp_valid_i (rsp_valid),
    .rsp_data_i  (rsp_data),
    .rsp_ready_o (rsp_ready),
    .ovf_cnt_o   (ovf_cnt),
    .udf_cnt_o   (udf_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    cyc = 0; stb = 0; we = 0; wdat = '0;
    cmd_ready = 0; rsp_valid = 0; rsp_data = '0;
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  // One Wishbone access; lat = cycles from request to ack, -1 if none within the budget.
  task automatic wb_access(input logic w, input logic [31:0] d, output int lat, output logic [31:0] r);
    bit got = 0;
    cyc = 1; stb = 1; we = w; wdat = d;
    lat = -1; r = '0;
    for (int i = 1; i <= 3 * TIMEOUT; i++) begin
      tick();
      if (ack) begin
        got = 1; lat = i; r = rdat;
        break;
      end
    end
    cyc = 0; stb = 0;
    tick();
    if (got) chk("ack_single", {31'd0, ack}, 32'd0);
  endtask

  task automatic core_push(input logic [31:0] d);
    rsp_valid = 1; rsp_data = d;
    tick();
    rsp_valid = 0;
  endtask

  task automatic core_pop();
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
  endtask

  localparam int OP_WR = 0, OP_RD = 1, OP_RSP = 2, OP_POP = 3, OP_VLD = 4;

  typedef struct {
    int          op;
    logic [31:0] d;
    int          lat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input int op, input logic [31:0] d, input int lat, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.d = d; v.lat = lat; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    int          lat;
    logic [31:0] r;
    int          n_ovf, n_udf;
    logic [31:0] cq[$];
    logic [31:0] rq[$];

    // Directed table: {op, data, expected latency, expected value}.
    add(OP_WR, 32'h11, LAT_OK, 32'h0);
    add(OP_VLD, 0, 0, 32'h1);
    add(OP_POP, 0, 0, 32'h11);
    add(OP_VLD, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) add(OP_WR, 32'hA0 + i, LAT_OK, 32'h0);
    add(OP_WR, 32'hA4, LAT_TO, 32'h0);
    for (int i = 0; i < 4; i++) add(OP_POP, 0, 0, 32'hA0 + i);
    add(OP_VLD, 0, 0, 32'h0);
    add(OP_RD, 0, LAT_TO, 32'hFFFF_FFFF);
    for (int i = 1; i <= 4; i++) add(OP_RSP, i, 0, 32'h1);
    add(OP_RSP, 32'h5, 0, 32'h0);
    for (int i = 1; i <= 4; i++) add(OP_RD, 0, LAT_OK, i);

    do_reset();
    chk("rst_ack", {31'd0, ack}, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 0);
    chk("rst_cmd_data", cmd_data, 0);
    chk("rst_rsp_ready", {31'd0, rsp_ready}, 1);
    chk("rst_ovf", {24'd0, ovf_cnt}, 0);
    chk("rst_udf", {24'd0, udf_cnt}, 0);

    foreach (vecs[k]) begin
      case (vecs[k].op)
        OP_WR, OP_RD: begin
          wb_access(vecs[k].op == OP_WR, vecs[k].d, lat, r);
          chk($sformatf("tbl%0d_lat", k), lat, vecs[k].lat);
          chk($sformatf("tbl%0d_dat", k), r, vecs[k].exp);
        end
        OP_RSP: begin
          chk($sformatf("tbl%0d_rsp_ready", k), {31'd0, rsp_ready}, vecs[k].exp);
          core_push(vecs[k].d);
        end
        OP_POP: begin
          chk($sformatf("tbl%0d_cmd_valid", k), {31'd0, cmd_valid}, 1);
          chk($sformatf("tbl%0d_cmd_data", k), cmd_data, vecs[k].exp);
          core_pop();
        end
        default: chk($sformatf("tbl%0d_cmd_valid", k), {31'd0, cmd_valid}, vecs[k].exp);
      endcase
    end
    chk("tbl_ovf", {24'd0, ovf_cnt}, 1);
    chk("tbl_udf", {24'd0, udf_cnt}, 1);
    chk("tbl_rsp_empty", {31'd0, rsp_ready}, 1);

    // Reset in the middle of a stalled write into a full command FIFO.
    for (int i = 0; i < 4; i++) wb_access(1, 32'hC0 + i, lat, r);
    cyc = 1; stb = 1; we = 1; wdat = 32'hC5;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_noack", {31'd0, ack}, 0);
    rst = 1;
    tick();
    chk("mid_rst_ack", {31'd0, ack}, 0);
    chk("mid_rst_cmd_valid", {31'd0, cmd_valid}, 0);
    chk("mid_rst_rsp_ready", {31'd0, rsp_ready}, 1);
    chk("mid_rst_ovf", {24'd0, ovf_cnt}, 0);
    chk("mid_rst_udf", {24'd0, udf_cnt}, 0);
    rst = 0;
    tick();
    chk("post_rst_ack", {31'd0, ack}, 1);
    chk("post_rst_cmd_valid", {31'd0, cmd_valid}, 1);
    chk("post_rst_cmd_data", cmd_data, 32'hC5);
    cyc = 0; stb = 0;
    tick();

    // Read stalls on empty; response arrives at wait cycle 10.
    do_reset();
    cyc = 1; stb = 1; we = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("late_rsp_noack", {31'd0, ack}, 0);
    rsp_valid = 1; rsp_data = 32'hBEEF;
    tick();
    rsp_valid = 0;
    chk("late_rsp_push_noack", {31'd0, ack}, 0);
    tick();
    chk("late_rsp_ack", {31'd0, ack}, 1);
    chk("late_rsp_dat", rdat, 32'hBEEF);
    cyc = 0; stb = 0;
    tick();
    chk("late_rsp_udf", {24'd0, udf_cnt}, 0);
    chk("late_rsp_hold", rdat, 32'hBEEF);

    // Abandoned read: no ack, no pop, no count.
    cyc = 1; stb = 1; we = 0;
    for (int i = 0; i < 4; i++) tick();
    cyc = 0; stb = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abandon_noack", {31'd0, ack}, 0);
    end
    core_push(32'h77);
    wb_access(0, 0, lat, r);
    chk("abandon_next_lat", lat, LAT_OK);
    chk("abandon_next_dat", r, 32'h77);
    chk("abandon_udf", {24'd0, udf_cnt}, 0);

    // Core holds rsp_valid through full; one read frees a slot for the held 5th word.
    do_reset();
    rsp_valid = 1;
    for (int i = 1; i <= 4; i++) begin
      rsp_data = i;
      tick();
    end
    rsp_data = 5;
    chk("hold_full", {31'd0, rsp_ready}, 0);
    tick();
    chk("hold_still_full", {31'd0, rsp_ready}, 0);
    cyc = 1; stb = 1; we = 0;
    tick();
    chk("hold_rd_ack", {31'd0, ack}, 1);
    chk("hold_rd_dat", rdat, 1);
    chk("hold_ready_back", {31'd0, rsp_ready}, 1);
    cyc = 0; stb = 0;
    tick();
    rsp_valid = 0;
    chk("hold_5_taken", {31'd0, rsp_ready}, 0);
    for (int i = 2; i <= 5; i++) begin
      wb_access(0, 0, lat, r);
      chk("hold_rd_lat", lat, LAT_OK);
      chk("hold_rd_val", r, i);
    end

    // Random operations against a queue-level model.
    do_reset();
    n_ovf = 0; n_udf = 0;
    for (int n = 0; n < 160; n++) begin
      logic [31:0] d;
      d = $urandom;
      case ($urandom_range(0, 3))
        0: begin
          wb_access(1, d, lat, r);
          if (cq.size() < DEPTH) begin
            cq.push_back(d);
            chk("rnd_wr_lat", lat, LAT_OK);
          end else begin
            n_ovf = (n_ovf < 255) ? n_ovf + 1 : 255;
            chk("rnd_wr_lat_to", lat, LAT_TO);
          end
          chk("rnd_wr_dat", r, 0);
        end
        1: begin
          wb_access(0, 0, lat, r);
          if (rq.size() > 0) begin
            chk("rnd_rd_lat", lat, LAT_OK);
            chk("rnd_rd_dat", r, rq.pop_front());
          end else begin
            n_udf = (n_udf < 255) ? n_udf + 1 : 255;
            chk("rnd_rd_lat_to", lat, LAT_TO);
            chk("rnd_rd_dat_to", r, 32'hFFFF_FFFF);
          end
        end
        2: begin
          chk("rnd_rsp_ready", {31'd0, rsp_ready}, (rq.size() < DEPTH) ? 1 : 0);
          if (rq.size() < DEPTH) rq.push_back(d);
          core_push(d);
        end
        default: begin
          chk("rnd_cmd_valid", {31'd0, cmd_valid}, (cq.size() > 0) ? 1 : 0);
          if (cq.size() > 0) chk("rnd_cmd_data", cmd_data, cq.pop_front());
          core_pop();
        end
      endcase
    end
    chk("rnd_ovf", {24'd0, ovf_cnt}, n_ovf);
    chk("rnd_udf", {24'd0, udf_cnt}, n_udf);

    // Underflow counter saturates at 255.
    do_reset();
    for (int i = 1; i <= 257; i++) begin
      wb_access(0, 0, lat, r);
      if (i == 255) chk("sat_udf_255", {24'd0, udf_cnt}, 255);
    end
    chk("sat_udf_hold", {24'd0, udf_cnt}, 255);
    chk("sat_last_dat", r, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
